// File: rtl/vect_pkg.sv
// vect_pkg
//   Shared types for the lane-serial vector execute stage.
//   vop_t   : 3-bit lane operation code
//   state_t : execute FSM states
package vect_pkg;

  typedef enum logic [2:0] {
    VOP_ADD  = 3'b000,
    VOP_SUB  = 3'b001,
    VOP_AND  = 3'b010,
    VOP_OR   = 3'b011,
    VOP_XOR  = 3'b100,
    VOP_MUL  = 3'b101,
    VOP_SHL  = 3'b110,
    VOP_PASS = 3'b111
  } vop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vect_exec_unit_if.sv
// vect_exec_unit_if
//   Operand/result bundle between the decode->execute pipeline register
//   and the vector execute stage.
//   master : pipeline side, drives start/op/ctrl_in/vect1/vect2,
//            receives result/ctrl_out/done/stall
//   slave  : execute stage, the mirror image
interface vect_exec_unit_if #(
  parameter int WIDTH        = 8,
  parameter int registerSize = 8,
  parameter int vectorSize   = 4
);
  import vect_pkg::*;

  logic                                     start;
  vop_t                                     op;
  logic [WIDTH-1:0]                         ctrl_in;
  logic [vectorSize-1:0][registerSize-1:0]  vect1;
  logic [vectorSize-1:0][registerSize-1:0]  vect2;
  logic [vectorSize-1:0][registerSize-1:0]  result;
  logic [WIDTH-1:0]                         ctrl_out;
  logic                                     done;
  logic                                     stall;

  modport master (
    output start, op, ctrl_in, vect1, vect2,
    input  result, ctrl_out, done, stall
  );

  modport slave (
    input  start, op, ctrl_in, vect1, vect2,
    output result, ctrl_out, done, stall
  );

endinterface

// File: rtl/vect_lane_alu.sv
// vect_lane_alu
//   Combinational single-lane ALU shared by every lane of the vector.
//   a_i, b_i : lane operands (registerSize bits)
//   op_i     : operation (vop_t)
//   y_o      : lane result, modulo 2^registerSize, no flags
module vect_lane_alu
  import vect_pkg::*;
#(
  parameter int registerSize = 8
) (
  input  logic [registerSize-1:0] a_i,
  input  logic [registerSize-1:0] b_i,
  input  vop_t                    op_i,
  output logic [registerSize-1:0] y_o
);

  localparam int SHW = (registerSize > 1) ? $clog2(registerSize) : 1;

  // Only the low log2(registerSize) bits of b form the shift amount, so a
  // shift never exceeds the lane width.
  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  // Every result is truncated to the lane width; carries are dropped.
  always_comb begin
    y_o = a_i;
    unique case (op_i)
      VOP_ADD:  y_o = a_i + b_i;
      VOP_SUB:  y_o = a_i - b_i;
      VOP_AND:  y_o = a_i & b_i;
      VOP_OR:   y_o = a_i | b_i;
      VOP_XOR:  y_o = a_i ^ b_i;
      VOP_MUL:  y_o = a_i * b_i;
      VOP_SHL:  y_o = a_i << shamt;
      VOP_PASS: y_o = a_i;
      default:  y_o = a_i;
    endcase
  end

endmodule

// File: rtl/vect_exec_unit.sv
// vect_exec_unit
//   Lane-serial vector execute stage. Latches the operand vectors and control
//   word on an accepted start, runs one lane per clock through a shared lane
//   ALU, then publishes the whole result vector with a one-cycle done pulse.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high
//   bus    : slave side of vect_exec_unit_if
//            start/op/ctrl_in/vect1/vect2 in, result/ctrl_out/done/stall out
module vect_exec_unit
  import vect_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int registerSize = 8,
  parameter int vectorSize   = 4
) (
  input  logic              clk,
  input  logic              reset,
  vect_exec_unit_if.slave   bus
);

  localparam int IW = (vectorSize > 1) ? $clog2(vectorSize) : 1;
  localparam logic [IW-1:0] LAST_LANE = IW'(vectorSize - 1);

  typedef logic [vectorSize-1:0][registerSize-1:0] vec_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q;
  vec_t              opA_q, opB_q;
  vop_t              op_q;
  logic [WIDTH-1:0]  ctrl_q;
  vec_t              buf_q, buf_d;
  vec_t              result_q;
  logic [WIDTH-1:0]  ctrlOut_q;
  logic              done_q;
  logic              stall_q;
  logic              accept;
  logic [registerSize-1:0] laneY;

  vect_lane_alu #(
    .registerSize (registerSize)
  ) u_alu (
    .a_i  (opA_q[idx_q]),
    .b_i  (opB_q[idx_q]),
    .op_i (op_q),
    .y_o  (laneY)
  );

  // A new operation is taken from IDLE or from DONE; starts seen in RUN are
  // ignored because upstream is stalled and its register is not yet new.
  assign accept = bus.start && (state_q == IDLE || state_q == DONE);

  // Next state, plus the working buffer with the current lane written in.
  // buf_d feeds result directly so the last lane is visible in the same
  // cycle done is raised.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        buf_d[idx_q] = laneY;
        if (idx_q == LAST_LANE) state_d = DONE;
      end
      DONE: state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, operand latches, lane counter and registered outputs. stall is
  // registered from the next state so it is high exactly while in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      op_q      <= VOP_ADD;
      ctrl_q    <= '0;
      buf_q     <= '0;
      result_q  <= '0;
      ctrlOut_q <= '0;
      done_q    <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= (state_d == RUN);
      done_q  <= 1'b0;
      if (accept) begin
        opA_q  <= bus.vect1;
        opB_q  <= bus.vect2;
        op_q   <= bus.op;
        ctrl_q <= bus.ctrl_in;
        idx_q  <= '0;
      end
      if (state_q == RUN) begin
        buf_q <= buf_d;
        if (idx_q == LAST_LANE) begin
          result_q  <= buf_d;
          ctrlOut_q <= ctrl_q;
          done_q    <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign bus.result   = result_q;
  assign bus.ctrl_out = ctrlOut_q;
  assign bus.done     = done_q;
  assign bus.stall    = stall_q;

endmodule

// File: tb/tb_vect_exec_unit.sv
// tb_vect_exec_unit
//   Directed, table-driven bench for vect_exec_unit with registerSize=8,
//   vectorSize=4, WIDTH=8, plus hand-written sequences for back-to-back
//   operation, input isolation during RUN and reset in the middle of RUN.
module tb_vect_exec_unit;
  import vect_pkg::*;

  localparam int W  = 8;
  localparam int RS = 8;
  localparam int VS = 4;

  typedef struct {
    string       name;
    vop_t        op;
    logic [7:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vecEntry_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vect_exec_unit_if #(.WIDTH(W), .registerSize(RS), .vectorSize(VS)) bus ();

  vect_exec_unit #(
    .WIDTH        (W),
    .registerSize (RS),
    .vectorSize   (VS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10-time-unit clock; outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input vop_t op,
                               input logic [7:0] ctrl,
                               input logic [31:0] a, input logic [31:0] b);
    bus.start   = st;
    bus.op      = op;
    bus.ctrl_in = ctrl;
    bus.vect1   = a;
    bus.vect2   = b;
  endtask

  // Single isolated operation: start for one cycle, stall for 4 cycles,
  // done in the fifth cycle with the result and control word.
  task automatic runVector(input vecEntry_t v);
    @(negedge clk);
    checkOutput({v.name, " idle done"}, {31'd0, bus.done}, 32'd0);
    applyStimulus(1'b1, v.op, v.ctrl, v.a, v.b);
    for (int k = 1; k <= VS; k++) begin
      @(negedge clk);
      if (k == 1) applyStimulus(1'b0, VOP_PASS, 8'h00, 32'h0, 32'h0);
      checkOutput({v.name, " stall"}, {31'd0, bus.stall}, 32'd1);
      checkOutput({v.name, " early done"}, {31'd0, bus.done}, 32'd0);
    end
    @(negedge clk);
    checkOutput({v.name, " done"}, {31'd0, bus.done}, 32'd1);
    checkOutput({v.name, " stall off"}, {31'd0, bus.stall}, 32'd0);
    checkOutput({v.name, " result"}, bus.result, v.exp);
    checkOutput({v.name, " ctrl_out"}, {24'd0, bus.ctrl_out}, {24'd0, v.ctrl});
  endtask

  vecEntry_t vt[$];
  logic      sawDone;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, VOP_ADD, 8'h00, 32'h0, 32'h0);

    // Reset state, checked before any clock edge.
    #2;
    checkOutput("reset result", bus.result, 32'h0);
    checkOutput("reset ctrl_out", {24'd0, bus.ctrl_out}, 32'h0);
    checkOutput("reset done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    vt.push_back('{"ADD wrap", VOP_ADD,  8'h5A, 32'hFF100180, 32'h01200280, 32'h00300300});
    vt.push_back('{"SUB",      VOP_SUB,  8'h11, 32'h0310F001, 32'h05100209, 32'hFE00EEF8});
    vt.push_back('{"MUL",      VOP_MUL,  8'h22, 32'h0310F001, 32'h05100209, 32'h0F00E009});
    vt.push_back('{"SHL",      VOP_SHL,  8'h33, 32'h0310F001, 32'h05100209, 32'h6010C002});
    vt.push_back('{"AND",      VOP_AND,  8'h44, 32'h0310F001, 32'h05100209, 32'h01100001});
    vt.push_back('{"OR",       VOP_OR,   8'h55, 32'h0310F001, 32'h05100209, 32'h0710F209});
    vt.push_back('{"XOR",      VOP_XOR,  8'h66, 32'h0310F001, 32'h05100209, 32'h0600F208});
    vt.push_back('{"PASS",     VOP_PASS, 8'h77, 32'h0310F001, 32'h05100209, 32'h0310F001});
    vt.push_back('{"ADD",      VOP_ADD,  8'h88, 32'h0310F001, 32'h05100209, 32'h0820F20A});

    foreach (vt[i]) runVector(vt[i]);

    // Back-to-back with input isolation: start stays high, inputs churn
    // during RUN, the second operation is presented in the DONE cycle.
    @(negedge clk);
    applyStimulus(1'b1, VOP_ADD, 8'hA1, 32'hFF100180, 32'h01200280);
    for (int k = 1; k <= VS; k++) begin
      @(negedge clk);
      checkOutput("b2b first stall", {31'd0, bus.stall}, 32'd1);
      applyStimulus(1'b1, vop_t'($urandom_range(0, 7)), 8'($urandom),
                    $urandom, $urandom);
    end
    @(negedge clk);
    checkOutput("b2b first done", {31'd0, bus.done}, 32'd1);
    checkOutput("b2b first result", bus.result, 32'h00300300);
    checkOutput("b2b first ctrl", {24'd0, bus.ctrl_out}, 32'h000000A1);
    applyStimulus(1'b1, VOP_SHL, 8'hB2, 32'h0310F001, 32'h05100209);
    for (int k = 1; k <= VS; k++) begin
      @(negedge clk);
      checkOutput("b2b second stall", {31'd0, bus.stall}, 32'd1);
      checkOutput("b2b no early done", {31'd0, bus.done}, 32'd0);
      checkOutput("b2b first result held", bus.result, 32'h00300300);
      applyStimulus(1'b1, vop_t'($urandom_range(0, 7)), 8'($urandom),
                    $urandom, $urandom);
    end
    @(negedge clk);
    applyStimulus(1'b0, VOP_PASS, 8'h00, 32'h0, 32'h0);
    checkOutput("b2b second done", {31'd0, bus.done}, 32'd1);
    checkOutput("b2b second result", bus.result, 32'h6010C002);
    checkOutput("b2b second ctrl", {24'd0, bus.ctrl_out}, 32'h000000B2);
    @(negedge clk);
    checkOutput("b2b done pulse ends", {31'd0, bus.done}, 32'd0);
    checkOutput("b2b back to idle", {31'd0, bus.stall}, 32'd0);

    // Reset in the middle of RUN, away from any clock edge.
    @(negedge clk);
    applyStimulus(1'b1, VOP_MUL, 8'hC3, 32'h0310F001, 32'h05100209);
    @(negedge clk);
    applyStimulus(1'b0, VOP_PASS, 8'h00, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrun reset result", bus.result, 32'h0);
    checkOutput("midrun reset ctrl", {24'd0, bus.ctrl_out}, 32'h0);
    checkOutput("midrun reset stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("midrun reset done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sawDone = 1'b0;
    for (int k = 0; k < 2 * VS; k++) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    checkOutput("midrun no done", {31'd0, sawDone}, 32'd0);
    checkOutput("midrun result still zero", bus.result, 32'h0);
    runVector(vt[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vect_exec_unit.md
# vect_exec_unit

Lane-serial vector execute stage placed directly downstream of the vector pipeline register between decode and execute. It consumes the registered operand vectors and control word, processes one lane per clock through a single shared lane ALU, and then presents the full result vector with a one-cycle done pulse. While it is working, it stalls the upstream pipeline register.

## Interface
- WIDTH, 8, width of the control word carried alongside the operands (destination, write-enable, etc.)
- registerSize, 8, bits per vector lane
- vectorSize, 4, lanes per vector (≥2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  operands valid; request a new operation
- op  in  3  operation code (vect_pkg::vop_t)
- ctrl_in  in  WIDTH  control word; travels with the operation
- vect1, vect2  in  [vectorSize-1:0][registerSize-1:0]  operand vectors A and B
- result  out  [vectorSize-1:0][registerSize-1:0]  result vector; holds its value until the next completion
- ctrl_out  out  WIDTH  control word of the operation that produced `result`
- done  out  1  one-cycle pulse when `result` / `ctrl_out` update
- stall  out  1  high while lanes are being processed; upstream must hold its register

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1:
  - latch vect1, vect2, op and ctrl_in into internal registers
  - clear lane index to 0
  - go to RUN
- IDLE with start=0: stay in IDLE.
- RUN, each cycle:
  - compute lane `idx` from the latched operands
  - write the value to the working result buffer at `idx`
  - increment idx
  - when idx==vectorSize-1, go to DONE
- RUN ignores start.
- DONE:
  - copy the working buffer to `result` and the latched ctrl to `ctrl_out`
  - assert done for this cycle only
  - if start=1, latch the new operands and go to RUN (back-to-back, no bubble); otherwise go to IDLE
- Ops. All arithmetic is modulo 2^registerSize; carries and overflow are discarded, with no flags.
  - 000 ADD: a+b
  - 001 SUB: a−b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 MUL: low registerSize bits of a*b
  - 110 SHL: a << b[$clog2(registerSize)-1:0]
  - 111 PASS: a
- The lane index counter is $clog2(vectorSize) bits wide. It never wraps past vectorSize-1 inside RUN.

## Timing
- start sampled at edge T (IDLE or DONE). Then:
  - stall is high for cycles T+1 … T+vectorSize
  - done is high in cycle T+vectorSize+1, and result is valid from that cycle on
- Latency from start to done: vectorSize+1 cycles.
- Maximum throughput: one operation per vectorSize+1 cycles.
- stall is a registered decode of state==RUN and is never high in IDLE or DONE. Upstream may therefore present the next operation during DONE.
- Reset (asynchronous, any state, including mid-RUN):
  - state goes to IDLE and the in-flight operation is discarded
  - result=0, ctrl_out=0, done=0, stall=0; the working buffer and idx are cleared
- First start after reset deassertion: sampled at the first rising edge with reset low.

## Structure
- Package vect_pkg holds:
  - typedef enum logic [2:0] vop_t (the opcodes above)
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE}
- Sub-module vect_lane_alu holds one lane of combinational logic:
  - inputs: a, b (registerSize), op (vop_t)
  - output: y (registerSize)
  - it is instantiated once and shared by all lanes.
- vect_exec_unit contains the FSM, operand/ctrl latches, lane counter, working buffer and output registers.

## Test plan
All values below use registerSize=8, vectorSize=4.
- Reset outputs: assert reset → result=0, ctrl_out=0, done=0, stall=0 immediately, without waiting for a clock edge.
- ADD with wrap: vect1={FF,10,01,80}, vect2={01,20,02,80}, op=ADD, ctrl_in=8'h5A, start for one cycle → stall high for 4 cycles; done at start+5; result={00,30,03,00}; ctrl_out=5A.
- SUB, MUL, SHL lanes: vect1={03,10,F0,01}, vect2={05,10,02,09}:
  - SUB → {FE,00,EE,F8}
  - MUL → {0F,00,E0,09}
  - SHL → {60,10,C0,02} (shift amount = b[2:0])
- Back-to-back: start held high through DONE with new operands → no IDLE cycle; second done arrives exactly 5 cycles after the first; the first result holds until then.
- Input isolation: start=1 with ops changing every cycle during RUN → results reflect only the operands latched at the accepting edge; starts during RUN are ignored.
- Reset mid-RUN: assert reset at lane 2 → immediate IDLE, no done pulse, result stays 0; a start after release completes normally with the correct result.
